// File: rtl/dehaze_pkg.sv
`default_nettype none
// ============================================================================
// Module : dehaze_pkg
// Brief  : Shared dehaze pipeline defaults and atmospheric-light FSM encodings.
// Rev    : 1.0  initial release
// ============================================================================
package dehaze_pkg;

    localparam int DEHAZE_DATA_WIDTH = 8;
    localparam int DEHAZE_IMG_WIDTH  = 320;
    localparam int DEHAZE_IMG_HEIGHT = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } ale_state_t;

endpackage : dehaze_pkg
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module : raster_counter
// Brief  : x/y raster position tracker; x/y give the position of the next pixel.
// Rev    : 1.0  initial release
// ============================================================================
module raster_counter
    import dehaze_pkg::*;
#(
    parameter int IMG_WIDTH  = DEHAZE_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEHAZE_IMG_HEIGHT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          advance,
    output logic [$clog2(IMG_WIDTH)-1:0]  x,
    output logic [$clog2(IMG_HEIGHT)-1:0] y,
    output logic                          last
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] C_X_MAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] C_Y_MAX = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] C_X_ONE = XW'(1);

    logic w_x_last;
    logic w_y_last;

    assign w_x_last = (x == C_X_MAX);
    assign w_y_last = (y == C_Y_MAX);
    assign last     = w_x_last && w_y_last;

    // start means the current pixel is (0,0), so the next one is (1,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (start) begin
            x <= C_X_ONE;
            y <= '0;
        end else if (advance) begin
            if (w_x_last) begin
                x <= '0;
                y <= w_y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule : raster_counter
`default_nettype wire

// File: rtl/atmos_light_est.sv
`default_nettype none
// ============================================================================
// Module : atmos_light_est
// Brief  : Per-frame atmospheric light estimate: RGB at the max dark-channel pixel.
// Rev    : 1.0  initial release
// ============================================================================
module atmos_light_est
    import dehaze_pkg::*;
#(
    parameter int DATA_WIDTH = DEHAZE_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEHAZE_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEHAZE_IMG_HEIGHT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic                          sof_in,
    input  logic [DATA_WIDTH-1:0]         dark_in,
    input  logic [DATA_WIDTH-1:0]         r_in,
    input  logic [DATA_WIDTH-1:0]         g_in,
    input  logic [DATA_WIDTH-1:0]         b_in,
    output logic                          a_valid,
    output logic [DATA_WIDTH-1:0]         a_r,
    output logic [DATA_WIDTH-1:0]         a_g,
    output logic [DATA_WIDTH-1:0]         a_b,
    output logic [DATA_WIDTH-1:0]         a_dark,
    output logic [$clog2(IMG_WIDTH)-1:0]  a_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] a_y,
    output logic                          busy
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    ale_state_t r_state;
    ale_state_t w_next_state;

    logic [XW-1:0]         w_x;
    logic [YW-1:0]         w_y;
    logic                  w_last;
    logic                  w_start;
    logic                  w_step;
    logic                  w_win;
    logic                  w_frame_end;

    logic [DATA_WIDTH-1:0] r_best_r;
    logic [DATA_WIDTH-1:0] r_best_g;
    logic [DATA_WIDTH-1:0] r_best_b;
    logic [DATA_WIDTH-1:0] r_best_dark;
    logic [XW-1:0]         r_best_x;
    logic [YW-1:0]         r_best_y;

    // sof restarts the frame from any state, including an unfinished ACCUM
    assign w_start     = valid_in && sof_in;
    assign w_step      = valid_in && !sof_in && (r_state == ST_ACCUM);
    assign w_win       = dark_in > r_best_dark;
    assign w_frame_end = w_step && w_last;

    raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .advance (w_step),
        .x       (w_x),
        .y       (w_y),
        .last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next_state = ST_ACCUM;
            end
            ST_ACCUM: begin
                busy = 1'b1;
                if (w_start)          w_next_state = ST_ACCUM;
                else if (w_frame_end) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = w_start ? ST_ACCUM : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_r    <= '0;
            r_best_g    <= '0;
            r_best_b    <= '0;
            r_best_dark <= '0;
            r_best_x    <= '0;
            r_best_y    <= '0;
        end else if (w_start) begin
            r_best_r    <= r_in;
            r_best_g    <= g_in;
            r_best_b    <= b_in;
            r_best_dark <= dark_in;
            r_best_x    <= '0;
            r_best_y    <= '0;
        end else if (w_step && w_win) begin
            r_best_r    <= r_in;
            r_best_g    <= g_in;
            r_best_b    <= b_in;
            r_best_dark <= dark_in;
            r_best_x    <= w_x;
            r_best_y    <= w_y;
        end
    end

    // Results are captured on the edge that accepts the last pixel, folding that
    // pixel in directly, so they are already stable during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_r     <= '0;
            a_g     <= '0;
            a_b     <= '0;
            a_dark  <= '0;
            a_x     <= '0;
            a_y     <= '0;
        end else begin
            a_valid <= w_frame_end;
            if (w_frame_end) begin
                a_r    <= w_win ? r_in    : r_best_r;
                a_g    <= w_win ? g_in    : r_best_g;
                a_b    <= w_win ? b_in    : r_best_b;
                a_dark <= w_win ? dark_in : r_best_dark;
                a_x    <= w_win ? w_x     : r_best_x;
                a_y    <= w_win ? w_y     : r_best_y;
            end
        end
    end

endmodule : atmos_light_est
`default_nettype wire

// File: tb/tb_atmos_light_est.sv
`default_nettype none
// ============================================================================
// Module : tb_atmos_light_est
// Brief  : Directed self-checking bench for atmos_light_est on a 4x3 frame.
// Rev    : 1.0  initial release
// ============================================================================
module tb_atmos_light_est;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          valid_in = 1'b0;
    logic          sof_in   = 1'b0;
    logic [DW-1:0] dark_in  = '0;
    logic [DW-1:0] r_in     = '0;
    logic [DW-1:0] g_in     = '0;
    logic [DW-1:0] b_in     = '0;
    logic          a_valid;
    logic [DW-1:0] a_r, a_g, a_b, a_dark;
    logic [1:0]    a_x, a_y;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int pulses     = 0;
    int last_acc   = 0;

    int            pc [8];
    logic [DW-1:0] pr [8];
    logic [DW-1:0] pg [8];
    logic [DW-1:0] pb [8];
    logic [DW-1:0] pd [8];
    logic [1:0]    px [8];
    logic [1:0]    py [8];

    atmos_light_est #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .sof_in   (sof_in),
        .dark_in  (dark_in),
        .r_in     (r_in),
        .g_in     (g_in),
        .b_in     (b_in),
        .a_valid  (a_valid),
        .a_r      (a_r),
        .a_g      (a_g),
        .a_b      (a_b),
        .a_dark   (a_dark),
        .a_x      (a_x),
        .a_y      (a_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            pc[pulses % 8] = cyc;
            pr[pulses % 8] = a_r;
            pg[pulses % 8] = a_g;
            pb[pulses % 8] = a_b;
            pd[pulses % 8] = a_dark;
            px[pulses % 8] = a_x;
            py[pulses % 8] = a_y;
            pulses = pulses + 1;
        end
    end

    task automatic send_pixel(input logic s, input logic [DW-1:0] d,
                              input logic [DW-1:0] r, input logic [DW-1:0] g,
                              input logic [DW-1:0] b);
        @(negedge clk);
        valid_in = 1'b1;
        sof_in   = s;
        dark_in  = d;
        r_in     = r;
        g_in     = g;
        b_in     = b;
        last_acc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            sof_in   = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL reset_a_valid: got %b expected 0", a_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (a_dark !== 8'd0 || a_r !== 8'd0 || a_g !== 8'd0 || a_b !== 8'd0) begin
            mismatched++; $display("FAIL reset_outputs: got dark=%0d r=%0d g=%0d b=%0d expected all 0", a_dark, a_r, a_g, a_b); end
        compared++; if (a_x !== 2'd0 || a_y !== 2'd0) begin mismatched++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0,0", a_x, a_y); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_ramp;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 6; i++) send_pixel(i == 0, 8'(i), 8'(i), 8'(2 * i), 8'(3 * i));
        #1;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ramp_busy: got %b expected 1", busy); end
        for (int i = 6; i < 12; i++) send_pixel(1'b0, 8'(i), 8'(i), 8'(2 * i), 8'(3 * i));
        idle(3);
        compared++; if (pulses - p0 !== 1) begin mismatched++; $display("FAIL ramp_pulses: got %0d expected 1", pulses - p0); end
        compared++; if (pc[p0 % 8] !== last_acc) begin mismatched++; $display("FAIL ramp_latency: got cycle %0d expected %0d", pc[p0 % 8], last_acc); end
        compared++; if (pd[p0 % 8] !== 8'd11) begin mismatched++; $display("FAIL ramp_dark: got %0d expected 11", pd[p0 % 8]); end
        compared++; if (pr[p0 % 8] !== 8'd11 || pg[p0 % 8] !== 8'd22 || pb[p0 % 8] !== 8'd33) begin
            mismatched++; $display("FAIL ramp_rgb: got %0d/%0d/%0d expected 11/22/33", pr[p0 % 8], pg[p0 % 8], pb[p0 % 8]); end
        compared++; if (px[p0 % 8] !== 2'd3 || py[p0 % 8] !== 2'd2) begin
            mismatched++; $display("FAIL ramp_xy: got %0d,%0d expected 3,2", px[p0 % 8], py[p0 % 8]); end
        compared++; if (a_dark !== 8'd11 || a_b !== 8'd33 || a_valid !== 1'b0) begin
            mismatched++; $display("FAIL ramp_hold: got dark=%0d b=%0d valid=%b expected 11/33/0", a_dark, a_b, a_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ramp_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_first_wins;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 12; i++)
            send_pixel(i == 0, (i == 2 || i == 7) ? 8'd50 : 8'd10, 8'(100 + i), 8'(i), 8'd7);
        idle(3);
        compared++; if (pulses - p0 !== 1) begin mismatched++; $display("FAIL tie_pulses: got %0d expected 1", pulses - p0); end
        compared++; if (px[p0 % 8] !== 2'd2 || py[p0 % 8] !== 2'd0) begin
            mismatched++; $display("FAIL tie_xy: got %0d,%0d expected 2,0", px[p0 % 8], py[p0 % 8]); end
        compared++; if (pd[p0 % 8] !== 8'd50 || pr[p0 % 8] !== 8'd102) begin
            mismatched++; $display("FAIL tie_value: got dark=%0d r=%0d expected 50/102", pd[p0 % 8], pr[p0 % 8]); end
    endtask

    task automatic test_abort;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 5; i++) send_pixel(i == 0, (i == 1) ? 8'd200 : 8'd5, 8'd200, 8'd200, 8'd200);
        for (int i = 0; i < 12; i++) send_pixel(i == 0, 8'(i + 1), 8'(i), 8'(i), 8'(i));
        idle(3);
        compared++; if (pulses - p0 !== 1) begin mismatched++; $display("FAIL abort_pulses: got %0d expected 1", pulses - p0); end
        compared++; if (pc[p0 % 8] !== last_acc) begin mismatched++; $display("FAIL abort_latency: got cycle %0d expected %0d", pc[p0 % 8], last_acc); end
        compared++; if (pd[p0 % 8] !== 8'd12 || pr[p0 % 8] !== 8'd11 || px[p0 % 8] !== 2'd3 || py[p0 % 8] !== 2'd2) begin
            mismatched++; $display("FAIL abort_result: got dark=%0d r=%0d xy=%0d,%0d expected 12/11/3,2",
                                   pd[p0 % 8], pr[p0 % 8], px[p0 % 8], py[p0 % 8]); end
    endtask

    task automatic test_back_to_back;
        int p0;
        int last_a;
        p0 = pulses;
        for (int i = 0; i < 12; i++) send_pixel(i == 0, (i == 5) ? 8'd90 : 8'd1, 8'd40, 8'd41, 8'd42);
        last_a = last_acc;
        for (int i = 0; i < 12; i++) send_pixel(i == 0, (i == 9) ? 8'd70 : 8'd2, 8'd60, 8'd61, 8'd62);
        idle(3);
        compared++; if (pulses - p0 !== 2) begin mismatched++; $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0); end
        compared++; if (pc[p0 % 8] !== last_a || pc[(p0 + 1) % 8] !== last_acc) begin
            mismatched++; $display("FAIL b2b_timing: got cycles %0d,%0d expected %0d,%0d", pc[p0 % 8], pc[(p0 + 1) % 8], last_a, last_acc); end
        compared++; if (pd[p0 % 8] !== 8'd90 || px[p0 % 8] !== 2'd1 || py[p0 % 8] !== 2'd1 || pr[p0 % 8] !== 8'd40) begin
            mismatched++; $display("FAIL b2b_first: got dark=%0d xy=%0d,%0d r=%0d expected 90/1,1/40",
                                   pd[p0 % 8], px[p0 % 8], py[p0 % 8], pr[p0 % 8]); end
        compared++; if (pd[(p0 + 1) % 8] !== 8'd70 || px[(p0 + 1) % 8] !== 2'd1 || py[(p0 + 1) % 8] !== 2'd2 || pr[(p0 + 1) % 8] !== 8'd60) begin
            mismatched++; $display("FAIL b2b_second: got dark=%0d xy=%0d,%0d r=%0d expected 70/1,2/60",
                                   pd[(p0 + 1) % 8], px[(p0 + 1) % 8], py[(p0 + 1) % 8], pr[(p0 + 1) % 8]); end
    endtask

    task automatic test_gaps;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                valid_in = 1'b0;
                sof_in   = 1'b0;
                dark_in  = 8'hFF;
            end
            send_pixel(i == 0, 8'(i), 8'(i), 8'(2 * i), 8'(3 * i));
        end
        idle(3);
        compared++; if (pulses - p0 !== 1) begin mismatched++; $display("FAIL gaps_pulses: got %0d expected 1", pulses - p0); end
        compared++; if (pc[p0 % 8] !== last_acc) begin mismatched++; $display("FAIL gaps_latency: got cycle %0d expected %0d", pc[p0 % 8], last_acc); end
        compared++; if (pd[p0 % 8] !== 8'd11 || pg[p0 % 8] !== 8'd22 || px[p0 % 8] !== 2'd3 || py[p0 % 8] !== 2'd2) begin
            mismatched++; $display("FAIL gaps_result: got dark=%0d g=%0d xy=%0d,%0d expected 11/22/3,2",
                                   pd[p0 % 8], pg[p0 % 8], px[p0 % 8], py[p0 % 8]); end
    endtask

    task automatic test_reset_midframe;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 6; i++) send_pixel(i == 0, 8'(i + 20), 8'd1, 8'd1, 8'd1);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        compared++; if (busy !== 1'b0 || a_dark !== 8'd0 || a_x !== 2'd0 || a_valid !== 1'b0) begin
            mismatched++; $display("FAIL midreset_clear: got busy=%b dark=%0d x=%0d valid=%b expected 0/0/0/0", busy, a_dark, a_x, a_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 6; i < 12; i++) send_pixel(1'b0, 8'd250, 8'd250, 8'd250, 8'd250);
        idle(3);
        compared++; if (pulses !== p0) begin mismatched++; $display("FAIL midreset_spurious: got %0d pulses expected 0", pulses - p0); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        for (int i = 0; i < 12; i++) send_pixel(i == 0, (i == 4) ? 8'd30 : 8'd3, 8'(i), 8'd5, 8'd6);
        idle(3);
        compared++; if (pulses - p0 !== 1) begin mismatched++; $display("FAIL midreset_pulses: got %0d expected 1", pulses - p0); end
        compared++; if (pd[p0 % 8] !== 8'd30 || pr[p0 % 8] !== 8'd4 || px[p0 % 8] !== 2'd0 || py[p0 % 8] !== 2'd1) begin
            mismatched++; $display("FAIL midreset_result: got dark=%0d r=%0d xy=%0d,%0d expected 30/4/0,1",
                                   pd[p0 % 8], pr[p0 % 8], px[p0 % 8], py[p0 % 8]); end
    endtask

    task automatic test_all_zero;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 12; i++)
            send_pixel(i == 0, 8'd0, (i == 0) ? 8'd9 : 8'd1, (i == 0) ? 8'd8 : 8'd1, (i == 0) ? 8'd7 : 8'd1);
        idle(3);
        compared++; if (pulses - p0 !== 1) begin mismatched++; $display("FAIL zero_pulses: got %0d expected 1", pulses - p0); end
        compared++; if (px[p0 % 8] !== 2'd0 || py[p0 % 8] !== 2'd0 || pd[p0 % 8] !== 8'd0) begin
            mismatched++; $display("FAIL zero_xy: got xy=%0d,%0d dark=%0d expected 0,0/0", px[p0 % 8], py[p0 % 8], pd[p0 % 8]); end
        compared++; if (pr[p0 % 8] !== 8'd9 || pg[p0 % 8] !== 8'd8 || pb[p0 % 8] !== 8'd7) begin
            mismatched++; $display("FAIL zero_rgb: got %0d/%0d/%0d expected 9/8/7", pr[p0 % 8], pg[p0 % 8], pb[p0 % 8]); end
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_first_wins;
        test_abort;
        test_back_to_back;
        test_gaps;
        test_reset_midframe;
        test_all_zero;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_atmos_light_est
`default_nettype wire

// File: doc/atmos_light_est.md
ATMOS_LIGHT_EST -- requirements
Module: atmos_light_est

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel component and dark-channel bit width.
REQ-002 SHALL have parameter IMG_WIDTH, default 320, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 240, lines per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port valid_in, input, 1, qualifies sof_in, dark_in, r_in, g_in and b_in.
REQ-007 SHALL have port sof_in, input, 1, marks the first pixel of a frame.
REQ-008 SHALL have port dark_in, input, DATA_WIDTH, dark-channel value of the current pixel.
REQ-009 SHALL have ports r_in, g_in and b_in, input, DATA_WIDTH each, source RGB aligned to dark_in.
REQ-010 SHALL have port a_valid, output, 1, one-cycle pulse when a frame result is published.
REQ-011 SHALL have ports a_r, a_g and a_b, output, DATA_WIDTH each, atmospheric light estimate.
REQ-012 SHALL have port a_dark, output, DATA_WIDTH, frame maximum dark-channel value.
REQ-013 SHALL have ports a_x and a_y, output, clog2(IMG_WIDTH) and clog2(IMG_HEIGHT), location of the winning pixel.
REQ-014 SHALL have port busy, output, 1, high while in ACCUM.

Function
REQ-015 SHALL implement states IDLE, ACCUM and DONE.
REQ-016 In IDLE, valid_in=1 with sof_in=1 SHALL load the pixel as the current best, set x=1, y=0 and enter ACCUM; valid pixels without sof_in SHALL be ignored.
REQ-017 In ACCUM, each valid pixel SHALL update the best only if dark_in > best_dark (strict), so the first occurrence wins ties.
REQ-018 Column counter x SHALL wrap from IMG_WIDTH-1 to 0 and increment y; the coordinates stored for the best are those of the winning pixel.
REQ-019 Accepting the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) SHALL include it in the comparison and enter DONE.
REQ-020 In DONE (exactly one cycle), a_valid SHALL be 1 and a_r, a_g, a_b, a_dark, a_x, a_y SHALL load the final best; the next state is IDLE.
REQ-021 Latency: a_valid SHALL assert on the cycle after the last frame pixel is accepted.
REQ-022 Outputs other than a_valid SHALL hold until the next DONE.
REQ-023 In ACCUM, sof_in=1 with valid_in=1 SHALL abort the partial frame with no a_valid and restart as in REQ-016 on that same pixel.
REQ-024 In DONE, valid_in with sof_in SHALL be accepted as the first pixel of the next frame (state goes to ACCUM), so back-to-back frames lose no pixels.
REQ-025 Gaps in valid_in SHALL stall counters and the best with no effect on the result.
REQ-026 A frame whose pixels are all 0 SHALL report the pixel at (0,0).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE and clear the counters, the best registers, all outputs, a_valid and busy to 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first post-reset output SHALL come only from a frame started by sof_in.

Structure
REQ-029 Default DATA_WIDTH, IMG_WIDTH and IMG_HEIGHT and the state encodings SHALL live in the shared dehaze parameter package/header.
REQ-030 The x/y raster counter SHALL be a sub-module named raster_counter, reusable by downstream stages.
REQ-031 No block RAM SHALL be used; storage is registers only.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3 unless stated)
REQ-032 12 pixels with dark = index and RGB = (index, 2*index, 3*index), sof on pixel 0 -> one a_valid on the cycle after pixel 11, a_dark=11, a_r=11, a_g=22, a_b=33, a_x=3, a_y=2.
REQ-033 dark=50 at pixels 2 and 7 and 10 elsewhere -> a_x=2, a_y=0, a_dark=50 (first occurrence wins).
REQ-034 sof reasserted at pixel 5, then a full frame -> exactly one a_valid, after the 12th pixel counted from the restart.
REQ-035 Two frames back-to-back with no gap and different maxima -> two a_valid pulses 12 cycles apart, each carrying its own frame maximum.
REQ-036 Random valid_in gaps (50% duty) on the REQ-032 stimulus -> identical result; rst_n pulsed at pixel 6 -> no a_valid until a new sof-started frame completes.
